// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx - receive-only PS/2 keyboard deframer.
//
// Samples the device-driven ps2_clk/ps2_data pair and synchronizes both
// lines. The clock is debounced by a level filter, and data is sampled on
// each filtered falling edge. 11-bit frames are deframed: start, 8 data
// bits LSB first, odd parity, stop. Good bytes are queued for the keyboard
// decoder.
//
// Build option: define PS2KBD_RX_FIFO_EN to get a FIFO_DEPTH-entry circular
// buffer. Without it, the queue is a single holding register.
//
// Ports:
//   clk_p      system clock
//   rst        asynchronous active-high reset
//   ps2_clk    PS/2 clock from the device (asynchronous)
//   ps2_data   PS/2 data from the device (asynchronous)
//   rx_data    head-of-queue byte, first-word-fall-through (0 when empty)
//   rx_ready   queue not empty
//   rx_ack     one-cycle pop strobe; ignored while the queue is empty
//   parity_err sticky: a parity failure occurred
//   frame_err  sticky: bad start bit, bad stop bit or mid-frame timeout
//   overrun    sticky: a good byte was dropped because the queue was full
//   err_clr    clears the three sticky flags (a same-cycle set wins)
//   busy       a frame is in progress
//
// Queue handshake: a byte is presented while rx_ready=1. Asserting rx_ack
// in such a cycle consumes it at that clock edge. The next byte, or
// rx_ready=0, is visible in the following cycle.
module ps2_kbd_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_p,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ack,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (FILTER_LEN < 2 || FILTER_LEN > 255) begin : g_bad_filter
    $error("FILTER_LEN must be in 2..255");
  end

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Input synchronizers. They reset to the idle-high line level.
  logic [1:0] clk_sync, data_sync;
  logic       clk_s, data_s;

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Clock filter. filt_cnt counts consecutive cycles in which the
  // synchronized clock differs from the accepted level. Any return to the
  // accepted level restarts the count, so short glitches never get through.
  logic [7:0] filt_cnt;
  logic       filt_clk, filt_clk_d, fall;

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      filt_cnt   <= 8'd0;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
    end else begin
      filt_clk_d <= filt_clk;
      if (clk_s == filt_clk) begin
        filt_cnt <= 8'd0;
      end else if (filt_cnt == 8'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s;
        filt_cnt <= 8'd0;
      end else begin
        filt_cnt <= filt_cnt + 8'd1;
      end
    end
  end

  assign fall = filt_clk_d & ~filt_clk;

  // Frame FSM.
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          push;
  logic [7:0]    push_byte;
  logic          timeout, parity_ok, frame_set, parity_set;

  assign timeout   = (state != IDLE) && (to_cnt == TW'(TIMEOUT));
  assign parity_ok = ^{shreg, par_bit};
  assign busy      = (state != IDLE);

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      push      <= 1'b0;
      push_byte <= 8'h00;
    end else begin
      push <= 1'b0;
      if (timeout) begin
        state  <= IDLE;
        to_cnt <= '0;
      end else if (fall) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!data_s) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_s;
            state   <= STOP;
          end
          default: begin
            if (data_s && parity_ok) begin
              push      <= 1'b1;
              push_byte <= shreg;
            end
            state <= IDLE;
          end
        endcase
      end else if (state != IDLE) begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

  // A bad stop bit is reported as a framing error only, even if parity is
  // also wrong.
  assign frame_set  = timeout |
                      (fall & (((state == IDLE) & data_s) | ((state == STOP) & ~data_s)));
  assign parity_set = ~timeout & fall & (state == STOP) & data_s & ~parity_ok;

  // Receive queue.
  logic pop, push_ok, overrun_set;

`ifdef PS2KBD_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full;

  assign empty       = (wptr == rptr);
  assign full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop         = rx_ack & ~empty;
  assign push_ok     = push & (~full | pop);
  assign overrun_set = push & full & ~pop;
  assign rx_ready    = ~empty;
  assign rx_data     = empty ? 8'h00 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk_p) begin
    if (push_ok) mem[wptr[AW-1:0]] <= push_byte;
  end

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end
`else
  logic [7:0] hold;
  logic       hold_v;

  assign pop         = rx_ack & hold_v;
  assign push_ok     = push & (~hold_v | pop);
  assign overrun_set = push & hold_v & ~pop;
  assign rx_ready    = hold_v;
  assign rx_data     = hold_v ? hold : 8'h00;

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      hold   <= 8'h00;
      hold_v <= 1'b0;
    end else if (push_ok) begin
      hold   <= push_byte;
      hold_v <= 1'b1;
    end else if (pop) begin
      hold_v <= 1'b0;
    end
  end
`endif

  // Sticky flags. A set event in the same cycle as err_clr wins.
  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= (parity_err & ~err_clr) | parity_set;
      frame_err  <= (frame_err  & ~err_clr) | frame_set;
      overrun    <= (overrun    & ~err_clr) | overrun_set;
    end
  end

endmodule
